alu_seq: RTL

Parametrised, handshaked successor to the 4-bit combinational ALU. It extends the same operation encoding to WIDTH bits and adds shifts, an iterative multiply, and signed-overflow and negative flags. Results are registered, with valid/ready flow control on both sides. It sits between an operand-issue stage and a result-consuming stage. Single-cycle operations sustain one result per clock.

---
 rtl/alu_pkg.sv | 89 ++++++++
 rtl/alu_mul_iter.sv | 51 +++++
 rtl/alu_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and the single-cycle datapath for alu_seq.
// alu_single works on a 32-bit container and masks results down to the active width.
package alu_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [MAX_W-1:0] result;
        logic             carry;
        logic             overflow;
    } alu_res_t;

    // OP_MUL is iterative and handled outside this function; it yields zeros here.
    function automatic alu_res_t alu_single(
        input int unsigned      w,
        input op_e              op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input logic [4:0]       sh
    );
        alu_res_t           res;
        logic [MAX_W-1:0]   mask;
        logic [MAX_W-1:0]   am;
        logic [MAX_W-1:0]   bm;
        logic [MAX_W-1:0]   r;
        logic [2*MAX_W-1:0] wide;
        logic [4:0]         msb;
        logic [5:0]         wi;

        mask = (w >= MAX_W) ? '1 : ((32'd1 << w) - 32'd1);
        am   = a & mask;
        bm   = b & mask;
        msb  = 5'(w - 1);
        wi   = 6'(w);
        res  = '0;
        wide = '0;
        r    = '0;

        case (op)
            OP_ADD: begin
                wide         = {32'b0, am} + {32'b0, bm};
                r            = wide[MAX_W-1:0] & mask;
                res.carry    = wide[wi];
                res.overflow = (am[msb] == bm[msb]) && (r[msb] != am[msb]);
            end
            OP_SUB: begin
                r            = (am - bm) & mask;
                res.carry    = (am < bm);
                res.overflow = (am[msb] != bm[msb]) && (r[msb] != am[msb]);
            end
            OP_AND: r = am & bm;
            OP_OR:  r = am | bm;
            OP_XOR: r = am ^ bm;
            OP_SHL: begin
                // bit w of the widened shift is the last bit pushed past the MSB
                wide      = {32'b0, am} << sh;
                r         = wide[MAX_W-1:0] & mask;
                res.carry = (sh != 5'd0) && wide[wi];
            end
            OP_SHR: begin
                wide      = {am, 32'b0} >> sh;
                r         = wide[2*MAX_W-1:MAX_W];
                res.carry = (sh != 5'd0) && wide[MAX_W-1];
            end
            default: r = '0;
        endcase

        res.result = r;
        return res;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier: one partial-product step per clock, WIDTH steps.
// product_o presents the post-step accumulator so the caller can capture it on the done cycle.
module alu_mul_iter import alu_pkg::*; #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   cnt_q;
    logic               busy_q;
    logic [WIDTH:0]     upper_sum;

    // Multiplier sits in the low half and is consumed LSB-first as the accumulator shifts right.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_d     = {upper_sum, acc_q[WIDTH-1:1]};
    end

    assign done_o    = busy_q && (cnt_q == WIDTH'(WIDTH - 1));
    assign product_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            acc_q   <= {{WIDTH{1'b0}}, b_i};
            mcand_q <= a_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result and flags.
// Single-cycle ops complete in one clock; MUL runs through alu_mul_iter for WIDTH clocks.
module alu_seq import alu_pkg::*; #(
    parameter  int unsigned WIDTH  = 8,
    localparam int unsigned CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [CTRL_W-1:0] control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  Result,
    output logic              Carry,
    output logic              Zero,
    output logic              Overflow,
    output logic              Negative
);

    localparam int unsigned SH_W = $clog2(WIDTH);

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_d;
    logic               carry_q;
    logic               carry_d;
    logic               ovf_q;
    logic               ovf_d;
    logic               xfer;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [4:0]         shamt;
    op_e                op;
    alu_res_t           single;
    logic               unused_single;

    assign op            = op_e'(control);
    assign shamt         = 5'(B[SH_W-1:0]);
    assign single        = alu_single(WIDTH, op, 32'(A), 32'(B), shamt);
    assign unused_single = ^single.result;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
    assign out_valid = (state_q == S_HOLD);
    assign xfer      = in_valid && in_ready;

    assign Result   = result_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;
    assign Zero     = (result_q == '0);
    assign Negative = result_q[WIDTH-1];

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (A),
        .b_i       (B),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;

        case (state_q)
            S_IDLE, S_HOLD: begin
                if (xfer) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        result_d = single.result[WIDTH-1:0];
                        carry_d  = single.carry;
                        ovf_d    = single.overflow;
                        state_d  = S_HOLD;
                    end
                end else if ((state_q == S_HOLD) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    result_d = mul_product[WIDTH-1:0];
                    carry_d  = |mul_product[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    state_d  = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
